// File: rtl/csr_timer_intc_pkg.sv
// Shared CSR map, TCFG field positions and the write-request payload for the
// timer / interrupt-controller CSR block.
package csr_timer_intc_pkg;

  localparam int unsigned CSR_NUM_W  = 14;
  localparam int unsigned CSR_DATA_W = 32;

  localparam logic [CSR_NUM_W-1:0] CSR_TMR_BASE = 14'h0100;
  localparam logic [CSR_NUM_W-1:0] CSR_TICLR    = 14'h0110;
  localparam logic [CSR_NUM_W-1:0] CSR_INTEN    = 14'h0111;
  localparam logic [CSR_NUM_W-1:0] CSR_INTPEND  = 14'h0112;

  localparam int unsigned TCFG_EN_BIT   = 0;
  localparam int unsigned TCFG_PER_BIT  = 1;
  localparam int unsigned TCFG_INIT_LSB = 2;

  typedef struct packed {
    logic                  we;
    logic [CSR_NUM_W-1:0]  num;
    logic [CSR_DATA_W-1:0] mask;
    logic [CSR_DATA_W-1:0] value;
  } csr_wr_t;

  function automatic logic [CSR_NUM_W-1:0] tcfg_addr(input int unsigned idx);
    return CSR_TMR_BASE + CSR_NUM_W'(2 * idx);
  endfunction

  function automatic logic [CSR_NUM_W-1:0] tval_addr(input int unsigned idx);
    return tcfg_addr(idx) + CSR_NUM_W'(1);
  endfunction

endpackage

// File: rtl/csr_timer_chan.sv
// One countdown timer channel: TCFG register, counter, pending flag and its
// TICLR clear, all decoded from the shared CSR write request.
module csr_timer_chan
  import csr_timer_intc_pkg::*;
#(
  parameter int unsigned TIMER_W  = 32,
  parameter int unsigned CHAN_IDX = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  csr_wr_t               csr_wr,
  output logic [CSR_DATA_W-1:0] tcfg_rdata,
  output logic [CSR_DATA_W-1:0] tval_rdata,
  output logic                  pend
);

  logic [TIMER_W-1:0] cfg_q, cfg_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               pend_q, pend_d;

  logic               cfg_hit_c;
  logic               clr_hit_c;
  logic [TIMER_W-1:0] cfg_new_c;
  logic [TIMER_W-1:0] reload_c;

  assign cfg_hit_c = csr_wr.we && (csr_wr.num == tcfg_addr(CHAN_IDX));
  assign clr_hit_c = csr_wr.we && (csr_wr.num == CSR_TICLR) &&
                     (|(csr_wr.mask & csr_wr.value & (CSR_DATA_W'(1) << CHAN_IDX)));

  assign cfg_new_c = (csr_wr.mask[TIMER_W-1:0] & csr_wr.value[TIMER_W-1:0]) |
                     (~csr_wr.mask[TIMER_W-1:0] & cfg_q);
  assign reload_c  = {cfg_q[TIMER_W-1:TCFG_INIT_LSB], {TCFG_INIT_LSB{1'b0}}};

  // A fresh enable-write reloads; otherwise step while enabled until parked at all-ones.
  always_comb begin
    cfg_d  = cfg_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;

    if (clr_hit_c) begin
      pend_d = 1'b0;
    end
    if (cfg_q[TCFG_EN_BIT] && (cnt_q == '0)) begin
      pend_d = 1'b1;
    end

    if (cfg_hit_c) begin
      cfg_d = cfg_new_c;
    end

    if (cfg_hit_c && cfg_new_c[TCFG_EN_BIT]) begin
      cnt_d = {cfg_new_c[TIMER_W-1:TCFG_INIT_LSB], {TCFG_INIT_LSB{1'b0}}};
    end else if (cfg_q[TCFG_EN_BIT] && (cnt_q != '1)) begin
      if ((cnt_q == '0) && cfg_q[TCFG_PER_BIT]) begin
        cnt_d = reload_c;
      end else begin
        cnt_d = cnt_q - TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q  <= '0;
      cnt_q  <= '1;
      pend_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign tcfg_rdata = CSR_DATA_W'(cfg_q);
  assign tval_rdata = CSR_DATA_W'(cnt_q);
  assign pend       = pend_q;

endmodule

// File: rtl/csr_timer_intc.sv
// CSR-mapped timer bank plus interrupt controller: synchronised external lines
// (level or sticky-edge), INTEN mask, INTPEND view and the global has_int.
module csr_timer_intc
  import csr_timer_intc_pkg::*;
#(
  parameter int unsigned         NUM_TIMERS = 2,
  parameter int unsigned         TIMER_W    = 32,
  parameter int unsigned         NUM_HWI    = 8,
  parameter logic [NUM_HWI-1:0]  HWI_EDGE   = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid,
  input  logic [CSR_NUM_W-1:0]           csr_num,
  input  logic                           csr_we,
  input  logic [CSR_DATA_W-1:0]          csr_wmask,
  input  logic [CSR_DATA_W-1:0]          csr_wvalue,
  output logic [CSR_DATA_W-1:0]          csr_rvalue,
  input  logic [NUM_HWI-1:0]             hw_int_in,
  input  logic                           crmd_ie,
  output logic [NUM_TIMERS+NUM_HWI-1:0]  int_pend,
  output logic                           has_int
);

  localparam int unsigned NUM_INT = NUM_TIMERS + NUM_HWI;

  csr_wr_t csr_wr;

  logic [CSR_DATA_W-1:0] tcfg_rd [NUM_TIMERS];
  logic [CSR_DATA_W-1:0] tval_rd [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] tmr_pend;

  logic [NUM_HWI-1:0] hwi_s1_q, hwi_s1_d;
  logic [NUM_HWI-1:0] hwi_s2_q, hwi_s2_d;
  logic [NUM_HWI-1:0] hwi_s3_q, hwi_s3_d;
  logic [NUM_HWI-1:0] hwi_sticky_q, hwi_sticky_d;
  logic [NUM_INT-1:0] inten_q, inten_d;

  logic [NUM_HWI-1:0] hwi_clr_c;
  logic [NUM_HWI-1:0] hwi_pend_c;

  assign csr_wr = '{we: valid & csr_we, num: csr_num, mask: csr_wmask, value: csr_wvalue};

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_chan
    csr_timer_chan #(
      .TIMER_W  (TIMER_W),
      .CHAN_IDX (g)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .csr_wr     (csr_wr),
      .tcfg_rdata (tcfg_rd[g]),
      .tval_rdata (tval_rd[g]),
      .pend       (tmr_pend[g])
    );
  end

  // Synchroniser chain; the third stage only feeds edge detection.
  always_comb begin
    hwi_s1_d  = hw_int_in;
    hwi_s2_d  = hwi_s1_q;
    hwi_s3_d  = hwi_s2_q;
    hwi_clr_c = '0;
    if (csr_wr.we && (csr_num == CSR_INTPEND)) begin
      hwi_clr_c = csr_wmask[NUM_HWI-1:0] & csr_wvalue[NUM_HWI-1:0];
    end
    // A new edge overrides a same-cycle software clear.
    hwi_sticky_d = ((hwi_sticky_q & ~hwi_clr_c) | (hwi_s2_q & ~hwi_s3_q)) & HWI_EDGE;

    inten_d = inten_q;
    if (csr_wr.we && (csr_num == CSR_INTEN)) begin
      inten_d = (csr_wmask[NUM_INT-1:0] & csr_wvalue[NUM_INT-1:0]) |
                (~csr_wmask[NUM_INT-1:0] & inten_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hwi_s1_q     <= '0;
      hwi_s2_q     <= '0;
      hwi_s3_q     <= '0;
      hwi_sticky_q <= '0;
      inten_q      <= '0;
    end else begin
      hwi_s1_q     <= hwi_s1_d;
      hwi_s2_q     <= hwi_s2_d;
      hwi_s3_q     <= hwi_s3_d;
      hwi_sticky_q <= hwi_sticky_d;
      inten_q      <= inten_d;
    end
  end

  assign hwi_pend_c = hwi_sticky_q | (hwi_s2_q & ~HWI_EDGE);
  assign int_pend   = {tmr_pend, hwi_pend_c};
  assign has_int    = crmd_ie & (|(int_pend & inten_q));

  // Read mux; unmapped addresses and TICLR fall through to zero.
  always_comb begin
    csr_rvalue = '0;
    if (csr_num == CSR_INTEN) begin
      csr_rvalue = CSR_DATA_W'(inten_q);
    end
    if (csr_num == CSR_INTPEND) begin
      csr_rvalue = CSR_DATA_W'(int_pend);
    end
    for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
      if (csr_num == tcfg_addr(i)) begin
        csr_rvalue = tcfg_rd[i];
      end
      if (csr_num == tval_addr(i)) begin
        csr_rvalue = tval_rd[i];
      end
    end
  end

endmodule
